sync_fifo: RTL and testbench

Single-clock, parametrised FIFO. Generalises the fixed 8×8 dual-port FIFO storage into a complete buffer with pointer management, occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a selectable read mode (standard or first-word-fall-through). It is the same-clock-domain buffer for datapaths that do not need the async FIFO's CDC logic.

---
 rtl/fifo_pkg.sv | 19 +
 rtl/fifo_ram.sv | 50 +++++
 rtl/sync_fifo.sv | 111 +++++++++++
 tb/tb_sync_fifo.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and elaboration-time helpers for the single-clock FIFO.
package fifo_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    // Address bits for `depth` entries plus one wrap bit.
    function automatic int ptr_width(input int depth);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << w) < depth) w++;
        end
        return w + 1;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Single-clock storage array with a synchronous write port and a read port
// that is either registered with enable (REG_RD=1) or combinational (REG_RD=0).
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int REG_RD = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [1 << ADDR_W];

    // Storage is never reset; the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    generate
        if (REG_RD != 0) begin : g_reg
            logic [DATA_W-1:0] rd_data_d;
            logic [DATA_W-1:0] rd_data_q;

            always_comb begin
                rd_data_d = rd_data_q;
                if (rd_en) rd_data_d = mem[rd_addr];
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) rd_data_q <= '0;
                else     rd_data_q <= rd_data_d;
            end

            assign rd_data = rd_data_q;
        end else begin : g_comb
            logic unused_ctrl;
            assign unused_ctrl = ^{rst, rd_en};
            assign rd_data     = mem[rd_addr];
        end
    endgenerate

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointer management, occupancy, threshold flags, sticky
// overflow/underflow and a standard or first-word-fall-through read port.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int         DATA_W = 8,
    parameter int         ADDR_W = 3,
    parameter fifo_mode_e MODE   = FIFO_STD,
    parameter int         AF_LVL = (1 << ADDR_W) - 1,
    parameter int         AE_LVL = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int PTR_W = ptr_width(DEPTH);
    localparam logic [PTR_W-1:0] AF_CNT = PTR_W'(AF_LVL);
    localparam logic [PTR_W-1:0] AE_CNT = PTR_W'(AE_LVL);

    logic [PTR_W-1:0] wptr_d, wptr_q;
    logic [PTR_W-1:0] rptr_d, rptr_q;
    logic             ovf_d, ovf_q;
    logic             udf_d, udf_q;
    logic             wr_acc, rd_acc;

    // Flags come only from registered pointers, so they lag the edge by one cycle.
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[PTR_W-1] != rptr_q[PTR_W-1]) &&
                   (wptr_q[PTR_W-2:0] == rptr_q[PTR_W-2:0]);
    assign count        = wptr_q - rptr_q;
    assign almost_full  = (count >= AF_CNT);
    assign almost_empty = (count <= AE_CNT);
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

    // No pass-through: acceptance looks only at the pre-edge flags.
    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        ovf_d  = ovf_q;
        udf_d  = udf_q;
        if (wr_acc)          wptr_d = wptr_q + PTR_W'(1);
        if (rd_acc)          rptr_d = rptr_q + PTR_W'(1);
        if (wr_en && full)   ovf_d  = 1'b1;
        if (rd_en && empty)  udf_d  = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            ovf_q  <= ovf_d;
            udf_q  <= udf_d;
        end
    end

    fifo_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .REG_RD ((MODE == FIFO_STD) ? 1 : 0)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_acc),
        .wr_addr (wptr_q[PTR_W-2:0]),
        .wr_data (wr_data),
        .rd_en   (rd_acc),
        .rd_addr (rptr_q[PTR_W-2:0]),
        .rd_data (rd_data)
    );

    generate
        if (MODE == FIFO_STD) begin : g_std
            logic rd_valid_d, rd_valid_q;

            // Registered read data is valid only in the cycle after an accepted read.
            assign rd_valid_d = rd_acc;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) rd_valid_q <= 1'b0;
                else     rd_valid_q <= rd_valid_d;
            end

            assign rd_valid = rd_valid_q;
        end else begin : g_fwft
            assign rd_valid = !empty;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: a standard-mode instance and a FWFT instance
// sharing clock and reset.
module tb_sync_fifo;
    import fifo_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0, rd_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic [7:0] rd_data;
    logic       rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [3:0] count;

    logic       f_wr_en = 1'b0, f_rd_en = 1'b0;
    logic [7:0] f_wr_data = 8'h00;
    logic [7:0] f_rd_data;
    logic       f_rd_valid, f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow;
    logic [3:0] f_count;

    int vectors = 0;
    int errs    = 0;

    always #5 clk = ~clk;

    sync_fifo #(.DATA_W(8), .ADDR_W(3), .MODE(FIFO_STD), .AF_LVL(6), .AE_LVL(1)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    sync_fifo #(.DATA_W(8), .ADDR_W(3), .MODE(FIFO_FWFT), .AF_LVL(6), .AE_LVL(1)) dut_f (
        .clk(clk), .rst(rst), .wr_en(f_wr_en), .wr_data(f_wr_data), .rd_en(f_rd_en),
        .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full), .empty(f_empty),
        .almost_full(f_almost_full), .almost_empty(f_almost_empty), .count(f_count),
        .overflow(f_overflow), .underflow(f_underflow)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        wr_en = 1'b1; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
    endtask

    task automatic do_reset();
        wr_en = 1'b0; rd_en = 1'b0; f_wr_en = 1'b0; f_rd_en = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        step(); step();
        rst = 1'b0;
        push(8'h3C);
        push(8'h3D);
        pop();
        vectors++; if (rd_data !== 8'h3C || rd_valid !== 1'b1) begin errs++; $display("FAIL pre_reset_read: got %h/%b want 3c/1", rd_data, rd_valid); end
        #2 rst = 1'b1;
        #1;
        vectors++; if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0) begin errs++; $display("FAIL async_reset_ptrs: got count=%0d empty=%b full=%b want 0/1/0", count, empty, full); end
        vectors++; if (almost_full !== 1'b0 || almost_empty !== 1'b1) begin errs++; $display("FAIL async_reset_thr: got af=%b ae=%b want 0/1", almost_full, almost_empty); end
        vectors++; if (rd_valid !== 1'b0 || rd_data !== 8'h00) begin errs++; $display("FAIL async_reset_rd: got %h/%b want 00/0", rd_data, rd_valid); end
        vectors++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errs++; $display("FAIL async_reset_err: got ovf=%b udf=%b want 0/0", overflow, underflow); end
        @(posedge clk); #1;
        rst = 1'b0;
        step();
        vectors++; if (empty !== 1'b1 || count !== 4'd0) begin errs++; $display("FAIL post_reset_idle: got empty=%b count=%0d want 1/0", empty, count); end
    endtask

    task automatic test_fill_overflow();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            push(8'h10 + 8'(i));
            vectors++; if (count !== 4'(i + 1)) begin errs++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, count, i + 1); end
            vectors++; if (almost_full !== (i + 1 >= 6)) begin errs++; $display("FAIL fill_af[%0d]: got %b want %b", i, almost_full, (i + 1 >= 6)); end
        end
        vectors++; if (full !== 1'b1 || overflow !== 1'b0) begin errs++; $display("FAIL fill_full: got full=%b ovf=%b want 1/0", full, overflow); end
        push(8'hFF);
        vectors++; if (overflow !== 1'b1 || count !== 4'd8) begin errs++; $display("FAIL overflow: got ovf=%b count=%0d want 1/8", overflow, count); end
        rd_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            vectors++; if (rd_valid !== 1'b1 || rd_data !== 8'h10 + 8'(i)) begin errs++; $display("FAIL drain[%0d]: got %h/%b want %h/1", i, rd_data, rd_valid, 8'h10 + 8'(i)); end
        end
        step();
        rd_en = 1'b0;
        vectors++; if (underflow !== 1'b1 || rd_valid !== 1'b0) begin errs++; $display("FAIL underflow: got udf=%b vld=%b want 1/0", underflow, rd_valid); end
        vectors++; if (rd_data !== 8'h17 || empty !== 1'b1 || almost_empty !== 1'b1) begin errs++; $display("FAIL drain_hold: got %h e=%b ae=%b want 17/1/1", rd_data, empty, almost_empty); end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 5; i++) push(8'h50 + 8'(i));
        rd_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            vectors++; if (rd_data !== 8'h50 + 8'(i)) begin errs++; $display("FAIL wrap_pre[%0d]: got %h want %h", i, rd_data, 8'h50 + 8'(i)); end
        end
        rd_en = 1'b0;
        for (int i = 0; i < 8; i++) push(8'hA0 + 8'(i));
        vectors++; if (full !== 1'b1 || count !== 4'd8) begin errs++; $display("FAIL wrap_full: got full=%b count=%0d want 1/8", full, count); end
        vectors++; if (dut.wptr_q !== 4'd13 || dut.rptr_q !== 4'd5) begin errs++; $display("FAIL wrap_ptrs: got w=%0d r=%0d want 13/5", dut.wptr_q, dut.rptr_q); end
        rd_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            vectors++; if (rd_valid !== 1'b1 || rd_data !== 8'hA0 + 8'(i)) begin errs++; $display("FAIL wrap_read[%0d]: got %h/%b want %h/1", i, rd_data, rd_valid, 8'hA0 + 8'(i)); end
        end
        rd_en = 1'b0;
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int i = 0; i < 4; i++) push(8'h20 + 8'(i));
        for (int i = 0; i < 10; i++) begin
            wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h24 + 8'(i);
            step();
            vectors++; if (count !== 4'd4 || rd_data !== 8'h20 + 8'(i)) begin errs++; $display("FAIL simul4[%0d]: got count=%0d data=%h want 4/%h", i, count, rd_data, 8'h20 + 8'(i)); end
        end
        wr_en = 1'b0; rd_en = 1'b0;
        do_reset();
        wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h77;
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        vectors++; if (count !== 4'd1 || underflow !== 1'b1 || rd_valid !== 1'b0) begin errs++; $display("FAIL simul_empty: got count=%0d udf=%b vld=%b want 1/1/0", count, underflow, rd_valid); end
        for (int i = 0; i < 7; i++) push(8'h80 + 8'(i));
        wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'hEE;
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        vectors++; if (count !== 4'd7 || overflow !== 1'b1 || full !== 1'b0) begin errs++; $display("FAIL simul_full: got count=%0d ovf=%b full=%b want 7/1/0", count, overflow, full); end
        vectors++; if (rd_valid !== 1'b1 || rd_data !== 8'h77) begin errs++; $display("FAIL simul_full_rd: got %h/%b want 77/1", rd_data, rd_valid); end
    endtask

    task automatic test_fwft();
        do_reset();
        vectors++; if (f_rd_valid !== 1'b0 || f_empty !== 1'b1) begin errs++; $display("FAIL fwft_idle: got vld=%b empty=%b want 0/1", f_rd_valid, f_empty); end
        f_wr_en = 1'b1; f_wr_data = 8'h55;
        step();
        f_wr_en = 1'b0;
        vectors++; if (f_rd_valid !== 1'b1 || f_rd_data !== 8'h55) begin errs++; $display("FAIL fwft_first: got %h/%b want 55/1", f_rd_data, f_rd_valid); end
        f_wr_en = 1'b1; f_wr_data = 8'h66;
        step();
        f_wr_en = 1'b0;
        vectors++; if (f_rd_data !== 8'h55 || f_count !== 4'd2) begin errs++; $display("FAIL fwft_head: got %h count=%0d want 55/2", f_rd_data, f_count); end
        f_rd_en = 1'b1;
        step();
        f_rd_en = 1'b0;
        vectors++; if (f_rd_valid !== 1'b1 || f_rd_data !== 8'h66) begin errs++; $display("FAIL fwft_pop1: got %h/%b want 66/1", f_rd_data, f_rd_valid); end
        f_rd_en = 1'b1;
        step();
        f_rd_en = 1'b0;
        vectors++; if (f_empty !== 1'b1 || f_rd_valid !== 1'b0 || f_underflow !== 1'b0) begin errs++; $display("FAIL fwft_pop2: got empty=%b vld=%b udf=%b want 1/0/0", f_empty, f_rd_valid, f_underflow); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        pop();
        vectors++; if (underflow !== 1'b1) begin errs++; $display("FAIL mid_udf_set: got %b want 1", underflow); end
        for (int i = 0; i < 5; i++) push(8'h30 + 8'(i));
        vectors++; if (count !== 4'd5) begin errs++; $display("FAIL mid_count5: got %0d want 5", count); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        vectors++; if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0 || almost_full !== 1'b0 || almost_empty !== 1'b1) begin errs++; $display("FAIL mid_flags: got count=%0d e=%b f=%b af=%b ae=%b want 0/1/0/0/1", count, empty, full, almost_full, almost_empty); end
        vectors++; if (overflow !== 1'b0 || underflow !== 1'b0 || rd_valid !== 1'b0) begin errs++; $display("FAIL mid_sticky: got ovf=%b udf=%b vld=%b want 0/0/0", overflow, underflow, rd_valid); end
        push(8'h01);
        pop();
        vectors++; if (rd_data !== 8'h01 || rd_valid !== 1'b1 || empty !== 1'b1) begin errs++; $display("FAIL mid_readback: got %h/%b empty=%b want 01/1/1", rd_data, rd_valid, empty); end
    endtask

    initial begin
        test_reset();
        test_fill_overflow();
        test_wrap();
        test_simultaneous();
        test_fwft();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
